// File: rtl/dvfs_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dvfs_seq_ctrl_if
// Brief    : Policy inputs, regulator req/ack link and applied V/F levels
//            of the multi-domain DVFS controller.
// Revision : 1.0 - initial release
// ============================================================================
interface dvfs_seq_ctrl_if #(
    parameter int N_DOM = 3,
    parameter int VW    = 2,
    parameter int FW    = 3
);
    logic                perf_req;
    logic [1:0]          temp;
    logic [1:0]          batt;
    logic [N_DOM-1:0]    workload;
    logic                vreg_ack;
    logic                vreg_req;
    logic [2:0]          vreg_dom;
    logic [VW-1:0]       vreg_lvl;
    logic [N_DOM*VW-1:0] vlvl;
    logic [N_DOM*FW-1:0] flvl;
    logic [2:0]          mode;
    logic                power_save;
    logic                busy;
    logic                err;

    // Controller side: owns the regulator request and the applied levels.
    modport master (
        input  perf_req, temp, batt, workload, vreg_ack,
        output vreg_req, vreg_dom, vreg_lvl, vlvl, flvl, mode, power_save, busy, err
    );

    modport slave (
        output perf_req, temp, batt, workload, vreg_ack,
        input  vreg_req, vreg_dom, vreg_lvl, vlvl, flvl, mode, power_save, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/dvfs_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dvfs_seq_ctrl
// Brief    : Multi-domain DVFS controller: policy FSM with dwell time plus a
//            per-domain V/F sequencer driving one shared regulator.
// Revision : 1.0 - initial release
// ============================================================================
module dvfs_seq_ctrl #(
    parameter int N_DOM  = 3,
    parameter int VW     = 2,
    parameter int FW     = 3,
    parameter int DWELL  = 16,
    parameter int ACK_TO = 64
) (
    input  wire             clk,
    input  wire             rst,
    dvfs_seq_ctrl_if.master bus
);
    localparam int c_DW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
    localparam int c_TW = (ACK_TO < 2) ? 1 : $clog2(ACK_TO);
    localparam logic [c_DW-1:0] c_DWELL   = c_DW'(DWELL);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(ACK_TO - 1);
    localparam logic [2:0]      c_LAST    = 3'(N_DOM - 1);

    localparam logic [VW-1:0] c_VMAX   = {VW{1'b1}};
    localparam logic [VW-1:0] c_VTHERM = VW'((2 ** VW) - 2);
    localparam logic [VW-1:0] c_VMID   = VW'(((2 ** VW) - 1) >> 1);
    localparam logic [FW-1:0] c_FMAX   = {FW{1'b1}};
    localparam logic [FW-1:0] c_FMID   = FW'(((2 ** FW) - 1) >> 1);
    localparam logic [FW-1:0] c_FONE   = FW'(1);

    localparam logic [2:0] c_M_NORMAL = 3'd0;
    localparam logic [2:0] c_M_PERF   = 3'd1;
    localparam logic [2:0] c_M_PSAVE  = 3'd2;
    localparam logic [2:0] c_M_THERM  = 3'd3;
    localparam logic [2:0] c_M_BATT   = 3'd4;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_VUP  = 2'd1;
    localparam logic [1:0] c_S_FSET = 2'd2;
    localparam logic [1:0] c_S_VDN  = 2'd3;

    logic             r_perf;
    logic [1:0]       r_temp;
    logic [1:0]       r_batt;
    logic [N_DOM-1:0] r_wl;
    logic [2:0]       r_mode;
    logic [c_DW-1:0]  r_dwell;
    logic [2:0]       w_want;
    logic             w_emerg;
    logic             w_mode_chg;

    logic [1:0]       r_state;
    logic [2:0]       r_dom;
    logic [2:0]       r_scan;
    logic [VW-1:0]    r_vt;
    logic [FW-1:0]    r_ft;
    logic             r_req;
    logic [VW-1:0]    r_lvl;
    logic             r_busy;
    logic             r_err;
    logic [c_TW-1:0]  r_timer;
    logic [7:0]       r_skip;
    logic [VW-1:0]    r_vlvl [8];
    logic [FW-1:0]    r_flvl [8];

    logic [VW-1:0]    w_vt [8];
    logic [FW-1:0]    w_ft [8];
    logic [7:0]       w_mis;
    logic             w_found;
    logic [2:0]       w_pick;
    logic [2:0]       w_next_dom;
    logic             w_timeout;
    logic [N_DOM*VW-1:0] w_vlvl_p;
    logic [N_DOM*FW-1:0] w_flvl_p;

    // Mode decision works on the registered copies, giving the 2-cycle latency.
    always_comb begin
        w_emerg = (r_batt == 2'b00) || (r_temp == 2'b11);
        if (r_batt == 2'b00)      w_want = c_M_BATT;
        else if (r_temp == 2'b11) w_want = c_M_THERM;
        else if (r_perf)          w_want = c_M_PERF;
        else if (r_batt == 2'b01) w_want = c_M_BATT;
        else if (r_temp == 2'b10) w_want = c_M_THERM;
        else if (r_wl == '0)      w_want = c_M_PSAVE;
        else                      w_want = c_M_NORMAL;
        w_mode_chg = (w_want != r_mode) && (w_emerg || (r_dwell >= c_DWELL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf  <= 1'b0;
            r_temp  <= 2'b00;
            r_batt  <= 2'b11;
            r_wl    <= '1;
            r_mode  <= c_M_NORMAL;
            r_dwell <= '0;
        end else begin
            r_perf <= bus.perf_req;
            r_temp <= bus.temp;
            r_batt <= bus.batt;
            r_wl   <= bus.workload;
            if (w_mode_chg) begin
                r_mode  <= w_want;
                r_dwell <= '0;
            end else if (r_dwell != c_DWELL) begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    // Per-domain targets; idle domains in NORMAL/PWR_SAVE stop the clock but hold V.
    always_comb begin
        for (int d = 0; d < 8; d++) begin
            w_vt[d] = '0;
            w_ft[d] = '0;
        end
        w_mis = '0;
        for (int d = 0; d < N_DOM; d++) begin
            case (r_mode)
                c_M_PERF:  begin w_vt[d] = c_VMAX;   w_ft[d] = c_FMAX; end
                c_M_THERM: begin w_vt[d] = c_VTHERM; w_ft[d] = c_FMID; end
                c_M_PSAVE: begin w_vt[d] = c_VMID;   w_ft[d] = c_FONE; end
                c_M_BATT:  begin w_vt[d] = '0;       w_ft[d] = '0;     end
                default:   begin w_vt[d] = c_VMID;   w_ft[d] = c_FMID; end
            endcase
            if (((r_mode == c_M_NORMAL) || (r_mode == c_M_PSAVE)) && !r_wl[d]) begin
                w_vt[d] = r_vlvl[d];
                w_ft[d] = '0;
            end
            w_mis[d] = !r_skip[d] && ((w_vt[d] != r_vlvl[d]) || (w_ft[d] != r_flvl[d]));
        end
    end

    // Round-robin pick of the first mismatched domain starting at r_scan.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N_DOM; k++) begin
            idx = int'(r_scan) + k;
            if (idx >= N_DOM) idx = idx - N_DOM;
            if (!w_found && w_mis[idx]) begin
                w_found = 1'b1;
                w_pick  = 3'(idx);
            end
        end
    end

    assign w_next_dom = (r_dom == c_LAST) ? 3'd0 : r_dom + 3'd1;
    assign w_timeout  = !bus.vreg_ack && (r_timer == c_TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_dom   <= '0;
            r_scan  <= '0;
            r_vt    <= '0;
            r_ft    <= '0;
            r_req   <= 1'b0;
            r_lvl   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_timer <= '0;
            r_skip  <= '0;
            for (int d = 0; d < 8; d++) begin
                r_vlvl[d] <= '0;
                r_flvl[d] <= '0;
            end
        end else begin
            // New targets give timed-out domains another chance.
            if (w_mode_chg) r_skip <= '0;
            case (r_state)
                c_S_IDLE: begin
                    r_busy <= w_found;
                    if (w_found) begin
                        r_dom <= w_pick;
                        r_vt  <= w_vt[w_pick];
                        r_ft  <= w_ft[w_pick];
                        if (w_vt[w_pick] > r_vlvl[w_pick]) begin
                            r_state <= c_S_VUP;
                            r_req   <= 1'b1;
                            r_lvl   <= w_vt[w_pick];
                            r_timer <= '0;
                        end else begin
                            r_state <= c_S_FSET;
                        end
                    end
                end
                c_S_FSET: begin
                    r_flvl[r_dom] <= r_ft;
                    if (r_vt < r_vlvl[r_dom]) begin
                        r_state <= c_S_VDN;
                        r_req   <= 1'b1;
                        r_lvl   <= r_vt;
                        r_timer <= '0;
                    end else begin
                        r_scan  <= w_next_dom;
                        r_state <= c_S_IDLE;
                    end
                end
                default: begin
                    if (bus.vreg_ack) begin
                        r_vlvl[r_dom] <= r_vt;
                        r_req         <= 1'b0;
                        if (r_state == c_S_VUP) begin
                            r_state <= c_S_FSET;
                        end else begin
                            r_scan  <= w_next_dom;
                            r_state <= c_S_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_req         <= 1'b0;
                        r_err         <= 1'b1;
                        r_skip[r_dom] <= 1'b1;
                        r_scan        <= w_next_dom;
                        r_state       <= c_S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_vlvl_p = '0;
        w_flvl_p = '0;
        for (int d = 0; d < N_DOM; d++) begin
            w_vlvl_p[d*VW +: VW] = r_vlvl[d];
            w_flvl_p[d*FW +: FW] = r_flvl[d];
        end
    end

    assign bus.vreg_req   = r_req;
    assign bus.vreg_dom   = r_dom;
    assign bus.vreg_lvl   = r_lvl;
    assign bus.vlvl       = w_vlvl_p;
    assign bus.flvl       = w_flvl_p;
    assign bus.mode       = r_mode;
    assign bus.power_save = (r_mode == c_M_PSAVE) || (r_mode == c_M_BATT);
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;
endmodule
`default_nettype wire

// File: tb/tb_dvfs_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvfs_seq_ctrl
// Brief    : Directed self-checking bench for dvfs_seq_ctrl (3 domains).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dvfs_seq_ctrl;
    logic clk;
    logic rst;
    logic auto_ack;
    logic man_ack;
    int   n_checks;
    int   n_fail;
    int   hs_cnt;
    int   viol;
    int   hs0;
    int   n;
    logic viol_now;

    dvfs_seq_ctrl_if #(.N_DOM(3), .VW(2), .FW(3)) bus ();

    dvfs_seq_ctrl #(
        .N_DOM(3), .VW(2), .FW(3), .DWELL(16), .ACK_TO(64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regulator model: acks one cycle after a request, or a manual level.
    always @(negedge clk) bus.vreg_ack <= auto_ack ? bus.vreg_req : man_ack;

    always @(posedge clk) if (!rst && bus.vreg_req && bus.vreg_ack) hs_cnt <= hs_cnt + 1;

    // Ordering invariants: F=FMAX only at V=VMAX, V=0 only at F=0, lowering V only after F=0.
    always_comb begin
        viol_now = 1'b0;
        for (int d = 0; d < 3; d++) begin
            if (bus.flvl[d*3 +: 3] == 3'd7 && bus.vlvl[d*2 +: 2] != 2'd3) viol_now = 1'b1;
            if (bus.vlvl[d*2 +: 2] == 2'd0 && bus.flvl[d*3 +: 3] != 3'd0) viol_now = 1'b1;
        end
        if (bus.vreg_req && bus.vreg_lvl == 2'd0 && bus.vreg_dom < 3'd3
            && bus.flvl[bus.vreg_dom*3 +: 3] != 3'd0) viol_now = 1'b1;
    end
    always @(negedge clk) if (!rst && viol_now) viol <= viol + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; hs_cnt = 0; viol = 0;
        auto_ack = 1'b1; man_ack = 1'b0;
        bus.perf_req = 1'b0; bus.temp = 2'b00; bus.batt = 2'b11; bus.workload = 3'b111;
        rst = 1'b0;
        #1 rst = 1'b1;
        tick(2);
        check("rst_mode", bus.mode, 64'd0);
        check("rst_vlvl", bus.vlvl, 64'd0);
        check("rst_flvl", bus.flvl, 64'd0);
        check("rst_req",  bus.vreg_req, 64'd0);
        check("rst_busy", bus.busy, 64'd0);
        check("rst_err",  bus.err, 64'd0);
        rst = 1'b0;

        // Test 1: ramp to NORMAL after reset
        tick(12);
        check("t1_vlvl", bus.vlvl, 64'h15);
        check("t1_flvl", bus.flvl, 64'h0DB);
        check("t1_mode", bus.mode, 64'd0);
        check("t1_busy", bus.busy, 64'd0);
        check("t1_hs",   hs_cnt, 64'd3);

        // Test 2: perf request held off by dwell, then V up before F up
        bus.perf_req = 1'b1;
        tick(4);
        check("t2_mode_dwell", bus.mode, 64'd0);
        tick(1);
        check("t2_mode_perf", bus.mode, 64'd1);
        tick(1);
        check("t2_req",      bus.vreg_req, 64'd1);
        check("t2_req_dom",  bus.vreg_dom, 64'd0);
        check("t2_req_lvl",  bus.vreg_lvl, 64'd3);
        tick(1);
        check("t2_v0_up",    bus.vlvl[1:0], 64'd3);
        check("t2_f0_hold",  bus.flvl[2:0], 64'd3);
        tick(1);
        check("t2_f0_up",    bus.flvl[2:0], 64'd7);
        tick(7);
        check("t2_vlvl", bus.vlvl, 64'h3F);
        check("t2_flvl", bus.flvl, 64'h1FF);
        check("t2_busy", bus.busy, 64'd0);

        // Test 3: battery emergency bypasses dwell, F down before V down
        bus.perf_req = 1'b0;
        bus.batt = 2'b00;
        tick(1);
        check("t3_mode_lat", bus.mode, 64'd1);
        tick(1);
        check("t3_mode", bus.mode, 64'd4);
        check("t3_psave", bus.power_save, 64'd1);
        tick(2);
        check("t3_vdn_req", bus.vreg_req, 64'd1);
        check("t3_vdn_lvl", bus.vreg_lvl, 64'd0);
        check("t3_f0_first", bus.flvl[2:0], 64'd0);
        check("t3_v0_hold", bus.vlvl[1:0], 64'd3);
        tick(8);
        check("t3_vlvl", bus.vlvl, 64'd0);
        check("t3_flvl", bus.flvl, 64'd0);
        check("t3_busy", bus.busy, 64'd0);

        // Test 4: back to NORMAL, then gate clocks of idle domains 0 and 2
        bus.batt = 2'b11;
        n = 0;
        while (bus.mode !== 3'd0 && n < 40) begin tick(1); n++; end
        check("t4_mode", bus.mode, 64'd0);
        tick(2);
        n = 0;
        while (bus.busy !== 1'b0 && n < 30) begin tick(1); n++; end
        check("t4_ramp_vlvl", bus.vlvl, 64'h15);
        check("t4_ramp_flvl", bus.flvl, 64'h0DB);
        hs0 = hs_cnt;
        bus.workload = 3'b010;
        tick(10);
        check("t4_vlvl", bus.vlvl, 64'h15);
        check("t4_flvl", bus.flvl, 64'h018);
        check("t4_no_hs", hs_cnt - hs0, 64'd0);
        check("t4_psave", bus.power_save, 64'd0);

        // Test 5: regulator never acks -> timeout, err, skip to next domain
        auto_ack = 1'b0;
        bus.perf_req = 1'b1;
        n = 0;
        while (bus.vreg_req !== 1'b1 && n < 20) begin tick(1); n++; end
        check("t5_req_rise", bus.vreg_req, 64'd1);
        check("t5_req_dom",  bus.vreg_dom, 64'd0);
        n = 0;
        while (bus.vreg_req === 1'b1 && n < 200) begin tick(1); n++; end
        check("t5_req_cycles", n, 64'd64);
        check("t5_err",  bus.err, 64'd1);
        check("t5_vlvl", bus.vlvl, 64'h15);
        check("t5_flvl", bus.flvl, 64'h018);
        tick(1);
        check("t5_next_req", bus.vreg_req, 64'd1);
        check("t5_next_dom", bus.vreg_dom, 64'd1);

        // Test 6: reset mid-handshake clears at once; ack at release is ignored
        #2 rst = 1'b1;
        #1;
        check("t6_req",  bus.vreg_req, 64'd0);
        check("t6_dom",  bus.vreg_dom, 64'd0);
        check("t6_lvl",  bus.vreg_lvl, 64'd0);
        check("t6_vlvl", bus.vlvl, 64'd0);
        check("t6_flvl", bus.flvl, 64'd0);
        check("t6_mode", bus.mode, 64'd0);
        check("t6_busy", bus.busy, 64'd0);
        check("t6_err",  bus.err, 64'd0);
        bus.perf_req = 1'b0;
        bus.workload = 3'b111;
        man_ack = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("t6_late_ack_vlvl", bus.vlvl, 64'd0);
        check("t6_new_req", bus.vreg_req, 64'd1);
        man_ack = 1'b0;
        auto_ack = 1'b1;
        tick(14);
        check("t6_vlvl", bus.vlvl, 64'h15);
        check("t6_flvl", bus.flvl, 64'h0DB);
        check("t6_err_clr", bus.err, 64'd0);

        check("order_violations", viol, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
